cnn1d_exp_horner: RTL

- Parametrised fixed-point exponential unit for the 1D CNN datapath, used ahead of softmax/normalisation stages.
- Successor to the fixed 10-factorial exp constants: arbitrary ORDER, DATA_WIDTH and FRACTION, with a selectable rounding mode and saturation.
- Evaluates exp(x) ≈ Σ_{k=0..ORDER} x^k/k! by iterative Horner recursion on one time-shared signed multiplier.
- Valid/ready handshake on both input and output sides.

---
 rtl/cnn1d_exp_horner_pkg.sv | 48 ++++
 rtl/cnn1d_exp_horner_mul_rq.sv | 41 ++++
 rtl/cnn1d_exp_horner.sv | 99 +++++++++
 3 files changed

// File: rtl/cnn1d_exp_horner_pkg.sv
// Shared fixed-point helpers for the 1D CNN datapath: defaults, FSM state type,
// elaboration-time factorial / reciprocal-factorial coefficients and a signed clamp.
package cnn1d_exp_horner_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_FRACTION   = 10;
  localparam int unsigned LPM_OUT_WIDTH      = 2 * DEFAULT_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } exp_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic longint unsigned factorial(input int unsigned k);
    longint unsigned f;
    f = 1;
    for (int unsigned i = 2; i <= k; i++) f = f * longint'(i);
    return f;
  endfunction

  // c_k = round(2^frac / k!) with half-up rounding in integer arithmetic
  function automatic longint unsigned recip_fact_coef(input int unsigned k,
                                                      input int unsigned frac);
    longint unsigned f;
    f = factorial(k);
    return ((64'd1 << frac) + f / 2) / f;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/cnn1d_exp_horner_mul_rq.sv
// Combinational signed multiply, requantise (optional half-up rounding),
// add-offset and saturate stage; shared by conv/dense/exp datapaths.
module cnn1d_fxp_mul_rq
  import cnn1d_exp_horner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FRACTION   = DEFAULT_FRACTION,
  parameter int unsigned ROUND_MODE = 1
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] addend,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         sat
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  // two guard bits keep the rounded/offset sum from wrapping before the clamp
  localparam int unsigned SW = PW + 2;
  localparam logic signed [SW-1:0] RND =
    (ROUND_MODE != 0) ? (SW'(1) << (FRACTION - 1)) : SW'(0);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] biased;
  logic signed [SW-1:0] sum;
  logic signed [63:0]   clamped;

  always_comb begin
    a_ext   = PW'(a);
    b_ext   = PW'(b);
    prod    = a_ext * b_ext;
    biased  = SW'(prod) + RND;
    sum     = (biased >>> FRACTION) + SW'(addend);
    clamped = sat_signed(64'(sum), DATA_WIDTH);
    y       = DATA_WIDTH'(clamped);
    sat     = (clamped != 64'(sum));
  end

endmodule

// File: rtl/cnn1d_exp_horner.sv
// Fixed-point exp(x) via Horner evaluation of the order-ORDER Taylor series,
// one time-shared multiplier, valid/ready on both sides.
module cnn1d_exp_horner
  import cnn1d_exp_horner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FRACTION   = DEFAULT_FRACTION,
  parameter int unsigned ORDER      = 8,
  parameter int unsigned ROUND_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_y,
  output logic                         out_sat
);

  localparam int unsigned KW = clog2(ORDER + 1);

  logic signed [DATA_WIDTH-1:0] coef [0:ORDER];

  for (genvar i = 0; i <= ORDER; i++) begin : g_coef
    assign coef[i] = DATA_WIDTH'(recip_fact_coef(i, FRACTION));
  end

  exp_state_t                   state;
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] x_reg;
  logic [KW-1:0]                k;
  logic                         sat_flag;
  logic signed [DATA_WIDTH-1:0] step_y;
  logic                         step_sat;

  cnn1d_fxp_mul_rq #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRACTION  (FRACTION),
    .ROUND_MODE(ROUND_MODE)
  ) u_mul_rq (
    .a     (acc),
    .b     (x_reg),
    .addend(coef[k]),
    .y     (step_y),
    .sat   (step_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      x_reg     <= '0;
      k         <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg    <= in_x;
            acc      <= coef[ORDER];
            k        <= KW'(ORDER - 1);
            sat_flag <= 1'b0;
            in_ready <= 1'b0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc      <= step_y;
          sat_flag <= sat_flag | step_sat;
          if (k == '0) begin
            // final step publishes straight from the multiplier output;
            // a negative result is forced to zero and reported as saturation
            out_valid <= 1'b1;
            out_y     <= step_y[DATA_WIDTH-1] ? '0 : step_y;
            out_sat   <= sat_flag | step_sat | step_y[DATA_WIDTH-1];
            state     <= ST_DONE;
          end else begin
            k <= k - KW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
